// File: rtl/fifo_rd_stream_out.sv
// Read-side output stage of the async FIFO: credit-based pop generation plus a 2-entry valid/ready output buffer.
// Optional beat counter output enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream_out #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  r_clk,
   input  logic                  rresetn,
   input  logic                  flush,
   input  logic                  empty,
   input  logic                  fifo_rd_enable,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_enable,
   output logic                  m_tvalid,
   output logic [DATA_WIDTH-1:0] m_tdata,
   input  logic                  m_tready
`ifdef FIFO_RD_STREAM_CNT_EN
   ,
   output logic [15:0]           beat_cnt
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ONE  = 2'd1;
   localparam logic [1:0] FULL = 2'd2;

   logic [1:0]            cnt;
   logic [1:0]            cnt_next;
   logic                  pend;
   logic [DATA_WIDTH-1:0] second;
   logic                  pop;
   logic [2:0]            credit_sum;

   // m_tvalid mirrors cnt != 0, so a pop never underflows the occupancy sum
   assign pop        = m_tvalid & m_tready;
   assign credit_sum = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};

   // Flush forces a pop so the read-pointer logic can rewind its pointer
   assign rd_enable = rresetn & (flush | (!empty & (credit_sum < 3'd2)));

   always_comb begin
      cnt_next = credit_sum[1:0];
      if (credit_sum > 3'd2) begin
         cnt_next = FULL;
      end
   end

   always_ff @(posedge r_clk or negedge rresetn) begin
      if (!rresetn) begin
         cnt      <= IDLE;
         pend     <= 1'b0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         second   <= '0;
      end else if (flush) begin
         cnt      <= IDLE;
         pend     <= 1'b0;
         m_tvalid <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         pend     <= fifo_rd_enable;
         m_tvalid <= (cnt_next != IDLE);
         case (cnt)
            IDLE: begin
               if (pend) begin
                  m_tdata <= rd_data;
               end
            end
            ONE: begin
               if (pend && pop) begin
                  m_tdata <= rd_data;
               end else if (pend) begin
                  second <= rd_data;
               end
            end
            FULL: begin
               if (pop) begin
                  m_tdata <= second;
                  if (pend) begin
                     second <= rd_data;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   always_ff @(posedge r_clk or negedge rresetn) begin
      if (!rresetn) begin
         beat_cnt <= 16'd0;
      end else if (flush) begin
         beat_cnt <= 16'd0;
      end else if (pop) begin
         beat_cnt <= beat_cnt + 16'd1;
      end
   end
`endif

endmodule
